uart_tx_arbiter: RTL and testbench

- Shares one UART TX serializer among N_REQ byte requesters using round-robin arbitration.
- Latches the winning byte and its parity configuration, then issues a single-cycle data_valid strobe to the TX core.
- Tracks the core's busy handshake until the frame completes.
- Sits between the requesters (register/FIFO clients) and the UART TX core.

---
 rtl/uart_tx_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares a single UART TX serializer between N_REQ byte requesters. A
// round-robin arbiter picks one pending request while idle, latches its byte
// and parity settings, fires a one-cycle launch strobe at the TX core, then
// follows the core's busy handshake until the frame finishes (or until busy
// never shows up, in which case the frame is dropped with an error pulse).
//
// Ports:
//   clk            system clock, everything on posedge
//   rst            synchronous reset, active-high
//   req_valid      per-requester request
//   req_data       packed request bytes, requester i at [i*DATA_W +: DATA_W]
//   req_par_en     per-requester parity enable
//   req_par_typ    per-requester parity type (0 even, 1 odd)
//   req_ready      one-hot, one-cycle accept pulse
//   tx_p_data      byte presented to the TX core
//   tx_data_valid  one-cycle launch strobe to the TX core
//   tx_par_en      parity enable to the TX core
//   tx_par_typ     parity type to the TX core
//   tx_busy        TX core busy
//   grant_id       index of the current / most recent winner
//   active         high from accept until the frame completes or is dropped
//   frame_done     one-cycle pulse when the core finishes the frame
//   timeout_err    one-cycle pulse when busy never rose after the strobe

module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_par_en,
  input  logic [N_REQ-1:0]           req_par_typ,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          tx_p_data,
  output logic                       tx_data_valid,
  output logic                       tx_par_en,
  output logic                       tx_par_typ,
  input  logic                       tx_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       active,
  output logic                       frame_done,
  output logic                       timeout_err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t            state, next_state;
  logic [ID_W-1:0]   rr_ptr, next_rr_ptr;
  logic [CNT_W-1:0]  cnt, next_cnt, cnt_inc;

  logic [N_REQ-1:0]  next_req_ready;
  logic [DATA_W-1:0] next_tx_p_data;
  logic              next_tx_data_valid;
  logic              next_tx_par_en;
  logic              next_tx_par_typ;
  logic [ID_W-1:0]   next_grant_id;
  logic              next_active;
  logic              next_frame_done;
  logic              next_timeout_err;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   winner_plus1;

  // Round-robin search: walk from rr_ptr upward, wrapping at N_REQ, and
  // keep the first requester that is asking. N_REQ need not be a power of
  // two, so the wrap is an explicit modulo rather than natural overflow.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
    winner_plus1 = ID_W'((int'(winner) + 1) % N_REQ);
  end

  assign cnt_inc = cnt + 1'b1;

  // Next-state and next-output logic. Every output is registered, so this
  // block computes what each output register should hold after the edge.
  // Pulse outputs default to 0; the latched byte, parity bits and grant
  // default to holding so they stay put until the next accept.
  always_comb begin
    next_state         = state;
    next_rr_ptr        = rr_ptr;
    next_cnt           = cnt;
    next_req_ready     = '0;
    next_tx_p_data     = tx_p_data;
    next_tx_data_valid = 1'b0;
    next_tx_par_en     = tx_par_en;
    next_tx_par_typ    = tx_par_typ;
    next_grant_id      = grant_id;
    next_active        = active;
    next_frame_done    = 1'b0;
    next_timeout_err   = 1'b0;

    case (state)
      IDLE: begin
        // A busy core means someone else is driving it or a frame is still
        // draining, so hold off even if requests are pending.
        if (!tx_busy && found) begin
          next_req_ready[winner] = 1'b1;
          next_tx_p_data         = req_data[int'(winner)*DATA_W +: DATA_W];
          next_tx_par_en         = req_par_en[winner];
          next_tx_par_typ        = req_par_typ[winner];
          next_grant_id          = winner;
          next_active            = 1'b1;
          next_rr_ptr            = winner_plus1;
          next_state             = LAUNCH;
        end
      end

      LAUNCH: begin
        next_tx_data_valid = 1'b1;
        next_cnt           = '0;
        next_state         = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        // Busy is checked before the counter so that busy arriving on the
        // very cycle the limit is reached still counts as a launched frame.
        if (tx_busy) begin
          next_state = WAIT_DONE;
        end else if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
          next_timeout_err = 1'b1;
          next_active      = 1'b0;
          next_cnt         = '0;
          next_state       = IDLE;
        end else begin
          next_cnt = cnt_inc;
        end
      end

      WAIT_DONE: begin
        if (!tx_busy) begin
          next_frame_done = 1'b1;
          next_active     = 1'b0;
          next_state      = GAP;
        end
      end

      GAP: begin
        // One dead cycle so consecutive launches always have a low cycle
        // between strobes.
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything, which also kills
  // any frame in flight without producing a done or error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      req_ready     <= '0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      tx_par_en     <= 1'b0;
      tx_par_typ    <= 1'b0;
      grant_id      <= '0;
      active        <= 1'b0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= next_state;
      rr_ptr        <= next_rr_ptr;
      cnt           <= next_cnt;
      req_ready     <= next_req_ready;
      tx_p_data     <= next_tx_p_data;
      tx_data_valid <= next_tx_data_valid;
      tx_par_en     <= next_tx_par_en;
      tx_par_typ    <= next_tx_par_typ;
      grant_id      <= next_grant_id;
      active        <= next_active;
      frame_done    <= next_frame_done;
      timeout_err   <= next_timeout_err;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//
// Bench for uart_tx_arbiter with N_REQ=4, DATA_W=8, BUSY_TIMEOUT=4. A small
// TX core model answers each launch strobe with a configurable busy delay
// and length. Expected launches are pushed into a scoreboard queue when a
// request is driven and popped by a monitor whenever the strobe appears.

module tb_uart_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int DATA_W       = 8;
  localparam int BUSY_TIMEOUT = 4;

  logic                     clk;
  logic                     rst;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic [N_REQ-1:0]         req_par_en;
  logic [N_REQ-1:0]         req_par_typ;
  logic [N_REQ-1:0]         req_ready;
  logic [DATA_W-1:0]        tx_p_data;
  logic                     tx_data_valid;
  logic                     tx_par_en;
  logic                     tx_par_typ;
  logic                     tx_busy;
  logic [1:0]               grant_id;
  logic                     active;
  logic                     frame_done;
  logic                     timeout_err;

  logic core_busy;
  logic ext_busy;
  int   core_delay;
  int   core_len;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int to_cnt   = 0;
  int model_ptr;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       pe;
    logic       pt;
  } exp_t;

  exp_t sb[$];

  assign tx_busy = core_busy | ext_busy;

  uart_tx_arbiter #(
    .N_REQ(N_REQ),
    .DATA_W(DATA_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_par_en(req_par_en),
    .req_par_typ(req_par_typ),
    .req_ready(req_ready),
    .tx_p_data(tx_p_data),
    .tx_data_valid(tx_data_valid),
    .tx_par_en(tx_par_en),
    .tx_par_typ(tx_par_typ),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // TX core model: after seeing a strobe, wait core_delay posedges, raise
  // busy, hold it core_len posedges. A negative delay means the core never
  // responds. Busy changes 1 time unit after the edge to avoid races.
  initial begin
    core_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_data_valid === 1'b1 && core_delay >= 0) begin
        repeat (core_delay) @(posedge clk);
        #1 core_busy = 1'b1;
        repeat (core_len) @(posedge clk);
        #1 core_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every launch strobe, counts completion
  // and error pulses, and checks accept pulses are one-hot.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_data_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_launch: unexpected strobe id=%0d data=%h, nothing expected", grant_id, tx_p_data);
        end else begin
          e = sb.pop_front();
          if ({grant_id, tx_p_data, tx_par_en, tx_par_typ} !== e) begin
            errors++;
            $display("[TB] FAIL sb_launch: got id=%0d data=%h pe=%b pt=%b, want id=%0d data=%h pe=%b pt=%b",
                     grant_id, tx_p_data, tx_par_en, tx_par_typ, e.id, e.data, e.pe, e.pt);
          end
        end
      end
      if (frame_done === 1'b1) done_cnt++;
      if (timeout_err === 1'b1) to_cnt++;
      if (frame_done === 1'b1 || timeout_err === 1'b1) begin
        checks++;
        if (frame_done === 1'b1 && timeout_err === 1'b1) begin
          errors++;
          $display("[TB] FAIL pulse_excl: frame_done=%b timeout_err=%b, want not both", frame_done, timeout_err);
        end
      end
      if (req_ready !== '0) begin
        checks++;
        if ($countones(req_ready) != 1 || active !== 1'b1) begin
          errors++;
          $display("[TB] FAIL ready_onehot: req_ready=%b active=%b, want one-hot with active=1", req_ready, active);
        end
      end
    end
  end

  function automatic int model_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return 0;
  endfunction

  // Predict the winner for this request pattern and queue its launch.
  task automatic push_expected(input logic [3:0] valid);
    int   w;
    exp_t e;
    w      = model_pick(valid, model_ptr);
    e.id   = w[1:0];
    e.data = req_data[w*DATA_W +: DATA_W];
    e.pe   = req_par_en[w];
    e.pt   = req_par_typ[w];
    sb.push_back(e);
    model_ptr = (w + 1) % N_REQ;
  endtask

  // Drive a request and wait (bounded) for the accept pulse.
  task automatic request(input logic [3:0] valid, input bit hold,
                         output logic [3:0] seen, output bit late);
    push_expected(valid);
    req_valid = valid;
    seen      = '0;
    late      = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready !== '0) begin
        seen = req_ready;
        late = 1'b0;
        break;
      end
    end
    if (!hold) req_valid = '0;
  endtask

  // Wait (bounded) for the frame to end by done or timeout, then one more
  // cycle so the arbiter is back in IDLE.
  task automatic wait_frame_end(output bit late);
    late = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1 || timeout_err === 1'b1) begin
        late = 1'b0;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_core_level(input logic lvl, output bit late);
    late = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_busy === lvl) begin
        late = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst       = 1'b1;
    req_valid = '0;
    ext_busy  = 1'b0;
    model_ptr = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_tx: ready=%b data=%h valid=%b pe=%b pt=%b, want all 0",
               req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ);
    end
    checks++;
    if ({grant_id, active, frame_done, timeout_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_status: grant=%0d active=%b done=%b to=%b, want all 0",
               grant_id, active, frame_done, timeout_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] seen;
    bit         late;
    bit         late2;
    $display("[TB] test_single");
    core_delay = 2;
    core_len   = 11;
    request(4'b0001, 1'b0, seen, late);
    checks++;
    if (late || seen !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_ready: req_ready=%b timed_out=%0d, want 0001", seen, late);
    end
    @(negedge clk);
    checks++;
    if (tx_data_valid !== 1'b1 || tx_p_data !== 8'hA5 || tx_par_en !== 1'b1 ||
        tx_par_typ !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("[TB] FAIL single_strobe: valid=%b data=%h pe=%b pt=%b grant=%0d, want 1 A5 1 0 0",
               tx_data_valid, tx_p_data, tx_par_en, tx_par_typ, grant_id);
    end
    @(negedge clk);
    checks++;
    if (tx_data_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_strobe_len: tx_data_valid=%b one cycle after strobe, want 0", tx_data_valid);
    end
    wait_core_level(1'b1, late);
    wait_core_level(1'b0, late2);
    checks++;
    if (late || late2 || frame_done !== 1'b0 || active !== 1'b1 || tx_p_data !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_hold: done=%b active=%b data=%h timed_out=%0d, want 0 1 A5",
               frame_done, active, tx_p_data, late | late2);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done: frame_done=%b active=%b one cycle after busy fall, want 1 0",
               frame_done, active);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done_len: frame_done=%b, want 0", frame_done);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seen;
    bit         late;
    bit         late2;
    int         d0;
    $display("[TB] test_round_robin");
    do_reset();
    core_delay = 2;
    core_len   = 3;
    for (int f = 0; f < N_REQ; f++) begin
      d0 = done_cnt;
      request(4'b1111, 1'b1, seen, late);
      checks++;
      if (late || seen !== 4'(1 << f)) begin
        errors++;
        $display("[TB] FAIL rr_order: frame %0d req_ready=%b timed_out=%0d, want %b", f, seen, late, 4'(1 << f));
      end
      wait_frame_end(late2);
      checks++;
      if (late2 || done_cnt != d0 + 1) begin
        errors++;
        $display("[TB] FAIL rr_done: frame %0d done pulses=%0d timed_out=%0d, want 1", f, done_cnt - d0, late2);
      end
    end
    req_valid = '0;
    request(4'b1001, 1'b0, seen, late);
    checks++;
    if (late || seen !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rr_wrap: req_ready=%b timed_out=%0d, want 0001", seen, late);
    end
    wait_frame_end(late2);
  endtask

  task automatic test_busy_hold();
    bit any_ready;
    bit late;
    $display("[TB] test_busy_hold");
    ext_busy = 1'b1;
    push_expected(4'b0100);
    req_valid = 4'b0100;
    any_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready !== '0) any_ready = 1'b1;
    end
    checks++;
    if (any_ready) begin
      errors++;
      $display("[TB] FAIL busy_block: req_ready pulsed while tx_busy=1, want none");
    end
    ext_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL busy_release: req_ready=%b after busy release, want 0100", req_ready);
    end
    req_valid = '0;
    wait_frame_end(late);
  endtask

  task automatic test_timeout();
    logic [3:0] seen;
    bit         late;
    int         d0;
    int         n;
    $display("[TB] test_timeout");
    core_delay = -1;
    d0 = done_cnt;
    request(4'b0010, 1'b0, seen, late);
    @(negedge clk);
    checks++;
    if (late || seen !== 4'b0010 || tx_data_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_launch: req_ready=%b strobe=%b timed_out=%0d, want 0010 1", seen, tx_data_valid, late);
    end
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != BUSY_TIMEOUT || active !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_pulse: timeout after %0d cycles active=%b done=%b, want %0d 0 0",
               n, active, frame_done, BUSY_TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("[TB] FAIL to_after: timeout_err=%b done pulses=%0d, want 0 0", timeout_err, done_cnt - d0);
    end
    core_delay = 2;
    request(4'b0010, 1'b0, seen, late);
    checks++;
    if (late || seen !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL to_recover: req_ready=%b timed_out=%0d, want 0010", seen, late);
    end
    wait_frame_end(late);
    checks++;
    if (late || done_cnt != d0 + 1) begin
      errors++;
      $display("[TB] FAIL to_recover_done: done pulses=%0d timed_out=%0d, want 1", done_cnt - d0, late);
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] seen;
    bit         late;
    bit         late2;
    int         d0;
    int         t0;
    $display("[TB] test_reset_midframe");
    core_delay = 2;
    core_len   = 8;
    request(4'b0100, 1'b0, seen, late);
    checks++;
    if (late || seen !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL mid_ready: req_ready=%b timed_out=%0d, want 0100", seen, late);
    end
    wait_core_level(1'b1, late);
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    t0 = to_cnt;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ, grant_id,
         active, frame_done, timeout_err} !== '0 || late) begin
      errors++;
      $display("[TB] FAIL mid_reset: ready=%b data=%h valid=%b grant=%0d active=%b timed_out=%0d, want all 0",
               req_ready, tx_p_data, tx_data_valid, grant_id, active, late);
    end
    rst = 1'b0;
    model_ptr = 0;
    wait_core_level(1'b0, late2);
    repeat (2) @(negedge clk);
    checks++;
    if (late2 || done_cnt != d0 || to_cnt != t0) begin
      errors++;
      $display("[TB] FAIL mid_no_pulse: done pulses=%0d timeout pulses=%0d timed_out=%0d, want 0 0",
               done_cnt - d0, to_cnt - t0, late2);
    end
    request(4'b1111, 1'b0, seen, late);
    checks++;
    if (late || seen !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL mid_restart: req_ready=%b timed_out=%0d, want 0001", seen, late);
    end
    wait_frame_end(late);
  endtask

  task automatic test_busy_boundary();
    logic [3:0] seen;
    bit         late;
    int         d0;
    int         t0;
    $display("[TB] test_busy_boundary");
    core_delay = BUSY_TIMEOUT - 1;
    core_len   = 4;
    d0 = done_cnt;
    t0 = to_cnt;
    request(4'b0010, 1'b0, seen, late);
    checks++;
    if (late || seen !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL edge_ready: req_ready=%b timed_out=%0d, want 0010", seen, late);
    end
    wait_frame_end(late);
    checks++;
    if (late || to_cnt != t0 || done_cnt != d0 + 1) begin
      errors++;
      $display("[TB] FAIL edge_busy_wins: timeout pulses=%0d done pulses=%0d timed_out=%0d, want 0 1",
               to_cnt - t0, done_cnt - d0, late);
    end
    core_delay = 2;
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    ext_busy    = 1'b0;
    core_delay  = 2;
    core_len    = 11;
    model_ptr   = 0;
    req_data    = {8'h3C, 8'h96, 8'h5A, 8'hA5};
    req_par_en  = 4'b1011;
    req_par_typ = 4'b0110;

    test_reset();
    test_single();
    test_round_robin();
    test_busy_hold();
    test_timeout();
    test_reset_midframe();
    test_busy_boundary();

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: %0d expected launches never seen, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
